// File: rtl/jump_pkg.sv
// Shared types and default tuning for the player jump controller.
// Trajectory states double as the debug/animation encoding.
package jump_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    APEX     = 2'd2,
    FALLING  = 2'd3
  } jstate_t;

  localparam int KEY_JUMP_BIT = 0;

  localparam int DEF_GROUND_Y    = 368;
  localparam int DEF_CEIL_Y      = 2;
  localparam int DEF_JUMP_V      = 6;
  localparam int DEF_GRAV_DIV    = 2;
  localparam int DEF_APEX_FRAMES = 2;
  localparam int DEF_MAX_FALL    = 6;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registered rising-edge detector for a single key bit.
// The edge is valid for exactly one frame per press.
module key_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic edge_o
);

  logic key_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) key_q <= 1'b0;
    else       key_q <= key_i;
  end

  assign edge_o = key_i & ~key_q;

endmodule

// File: rtl/jump_ctrl.sv
// Per-frame vertical velocity generator for the player sprite:
// rise, apex hold and fall with quantised gravity, landing on sprite_y.
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int CEIL_Y      = DEF_CEIL_Y,
  parameter int JUMP_V      = DEF_JUMP_V,
  parameter int GRAV_DIV    = DEF_GRAV_DIV,
  parameter int APEX_FRAMES = DEF_APEX_FRAMES,
  parameter int MAX_FALL    = DEF_MAX_FALL
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [9:0]  sprite_y,
  output logic [9:0]  up,
  output logic [9:0]  down,
  output logic        airborne,
  output logic [1:0]  jstate
);

  localparam int VMAX = (JUMP_V > MAX_FALL) ? JUMP_V : MAX_FALL;
  localparam int VW   = cbits(VMAX + 1);
  localparam int DW   = cbits(GRAV_DIV);
  localparam int AW   = cbits(APEX_FRAMES);

  jstate_t       state_q, state_d;
  logic [VW-1:0] vel_q, vel_d, vel_n;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] apex_q, apex_d;
  logic [9:0]    up_q, up_d;
  logic [9:0]    down_q, down_d;
  logic          air_q, air_d;

  logic          jump_edge;
  logic          div_wrap;
  logic [10:0]   y_ext;
  logic [10:0]   ceil_lim;
  logic [10:0]   fall_sum;
  logic [9:0]    land_gap;
  logic          unused_keys;

  key_edge_det u_jump_key (
    .clk_i  (frame_clk),
    .rst_i  (Reset),
    .key_i  (keycode[KEY_JUMP_BIT]),
    .edge_o (jump_edge)
  );

  assign unused_keys = ^keycode;

  // Widen to 11 bits so y + vel cannot wrap.
  assign y_ext    = {1'b0, sprite_y};
  assign ceil_lim = 11'(CEIL_Y) + 11'(vel_q);
  assign fall_sum = y_ext + 11'(vel_n);
  assign land_gap = 10'(GROUND_Y) - sprite_y;
  assign div_wrap = (div_q == DW'(GRAV_DIV - 1));

  always_comb begin
    vel_n = vel_q;
    if (div_wrap && (vel_q < VW'(MAX_FALL)))
      vel_n = vel_q + VW'(1);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= GROUNDED;
      vel_q   <= '0;
      div_q   <= '0;
      apex_q  <= '0;
      up_q    <= '0;
      down_q  <= '0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      div_q   <= div_d;
      apex_q  <= apex_d;
      up_q    <= up_d;
      down_q  <= down_d;
      air_q   <= air_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    div_d   = div_q;
    apex_d  = apex_q;
    up_d    = '0;
    down_d  = '0;
    unique case (state_q)
      GROUNDED: begin
        if (jump_edge) begin
          state_d = RISING;
          vel_d   = VW'(JUMP_V);
          div_d   = '0;
          up_d    = 10'd0 - 10'(JUMP_V);
        end
      end
      RISING: begin
        if (y_ext <= ceil_lim) begin
          state_d = FALLING;
          vel_d   = VW'(1);
          div_d   = '0;
          down_d  = 10'd1;
        end else if (div_wrap) begin
          div_d = '0;
          if (vel_q <= VW'(1)) begin
            state_d = APEX;
            vel_d   = '0;
            apex_d  = '0;
          end else begin
            vel_d = vel_q - VW'(1);
            up_d  = 10'd0 - 10'(vel_d);
          end
        end else begin
          div_d = div_q + DW'(1);
          up_d  = 10'd0 - 10'(vel_q);
        end
      end
      APEX: begin
        if (apex_q == AW'(APEX_FRAMES - 1)) begin
          state_d = FALLING;
          vel_d   = VW'(1);
          div_d   = '0;
          down_d  = 10'd1;
        end else begin
          apex_d = apex_q + AW'(1);
        end
      end
      FALLING: begin
        div_d = div_wrap ? '0 : div_q + DW'(1);
        if (y_ext >= 11'(GROUND_Y)) begin
          state_d = GROUNDED;
          vel_d   = '0;
          div_d   = '0;
        end else if (fall_sum >= 11'(GROUND_Y)) begin
          state_d = GROUNDED;
          vel_d   = '0;
          div_d   = '0;
          down_d  = land_gap;
        end else begin
          vel_d  = vel_n;
          down_d = 10'(vel_n);
        end
      end
    endcase
  end

  assign air_d = (state_d != GROUNDED);

  always_comb begin
    up       = up_q;
    down     = down_q;
    airborne = air_q;
    jstate   = state_q;
  end

endmodule
